// File: rtl/tf_rom_stream_pkg.sv
// Shared constants for the twiddle-factor ROM stream unit.
// Holds Q_TYPE codes, transform mode codes, FSM states and init paths.
package tf_rom_stream_pkg;

  localparam int Q_35Q0 = 0;
  localparam int Q_35Q1 = 1;
  localparam int Q_39Q  = 2;

  localparam logic MODE_NTT  = 1'b0;
  localparam logic MODE_INTT = 1'b1;

  localparam int TF_LANE_BITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } tf_state_e;

  function automatic string tf_path_base(input int q);
    case (q)
      Q_35Q1:  return "tf_init/35q1";
      Q_39Q:   return "tf_init/39q";
      default: return "tf_init/35q0";
    endcase
  endfunction

endpackage

// File: rtl/tf_rom_lane.sv
// One lane ROM: NTT table in the low half, INTT table in the high half.
// Ports: clk, rst, ce, addr {mode,index}, dout after DELAY cycles.
module tf_rom_lane
  import tf_rom_stream_pkg::*;
#(
  parameter int COE_WIDTH   = 39,
  parameter int ADDR_WIDTH  = 11,
  parameter int LANE        = 0,
  parameter int Q_TYPE      = Q_35Q0,
  parameter int DELAY       = 2,
  parameter bit ROM_PATTERN = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic [ADDR_WIDTH:0]   addr,
  output logic [COE_WIDTH-1:0]  dout
);

  localparam int DEPTH = 2 ** (ADDR_WIDTH + 1);
  localparam int HALF  = 2 ** ADDR_WIDTH;

  logic [COE_WIDTH-1:0] rom_word;
  logic [COE_WIDTH-1:0] pipe_q [DELAY];

  generate
    if (ROM_PATTERN) begin : g_pat
      localparam logic [TF_LANE_BITS-1:0] LANE_ID =
        TF_LANE_BITS'(LANE);
      assign rom_word = COE_WIDTH'({
        addr[ADDR_WIDTH],
        LANE_ID,
        addr[ADDR_WIDTH-1:0]
      });
    end else begin : g_file
      logic [COE_WIDTH-1:0] mem [DEPTH];
      initial begin
        for (int i = 0; i < DEPTH; i++) begin
          mem[i] = COE_WIDTH'(
            (longint'(Q_TYPE)
              << (ADDR_WIDTH + 1 + TF_LANE_BITS))
            | (longint'(LANE) << (ADDR_WIDTH + 1))
            | longint'(i));
        end
      end
      assign rom_word = mem[addr];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) pipe_q[i] <= '0;
    end else if (ce) begin
      pipe_q[0] <= rom_word;
      for (int i = 1; i < DELAY; i++) pipe_q[i] <= pipe_q[i-1];
    end
  end

  assign dout = pipe_q[DELAY-1];

endmodule

// File: rtl/tf_rom_stream.sv
// Twiddle fetch unit: burst address generator feeding NUM_LANE lane ROMs.
// In: start/mode/base_addr/stride/length, hold. Out: busy, done, tf_*.
module tf_rom_stream
  import tf_rom_stream_pkg::*;
#(
  parameter int COE_WIDTH         = 39,
  parameter int ADDR_WIDTH        = 11,
  parameter int NUM_LANE          = 4,
  parameter int Q_TYPE            = Q_35Q0,
  parameter int COMMON_BRAM_DELAY = 2,
  parameter int LEN_WIDTH         = ADDR_WIDTH + 1,
  parameter bit ROM_PATTERN       = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          mode,
  input  logic [ADDR_WIDTH-1:0]         base_addr,
  input  logic [ADDR_WIDTH-1:0]         stride,
  input  logic [LEN_WIDTH-1:0]          length,
  input  logic                          hold,
  output logic                          busy,
  output logic                          done,
  output logic                          tf_valid,
  output logic [NUM_LANE*COE_WIDTH-1:0] tf_data,
  output logic [LEN_WIDTH-1:0]          tf_index
);

  localparam int D = COMMON_BRAM_DELAY;
  localparam logic [D-1:0] OUT_STAGE = D'(1 << (D - 1));

  tf_state_e state_q, state_d;

  logic                  mode_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] stride_q;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  cnt_q;
  logic                  done_q;

  logic [D-1:0]          vld_q;
  logic [LEN_WIDTH-1:0]  idx_q [D];

  logic load;
  logic issue;
  logic done_set;
  logic last_issue;
  logic drained;

  assign last_issue = cnt_q == len_q - LEN_WIDTH'(1);

  // Leave DRAIN once the last word sits in the output stage, so
  // done lands in the cycle right after that word is shown.
  assign drained = (vld_q & ~OUT_STAGE) == '0;

  always_comb begin
    state_d  = state_q;
    load     = 1'b0;
    issue    = 1'b0;
    done_set = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = (length == '0) ? ST_DRAIN : ST_RUN;
        end
      end
      ST_RUN: begin
        if (!hold) begin
          issue = 1'b1;
          if (last_issue) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!hold && drained) begin
          done_set = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_NTT;
      addr_q   <= '0;
      stride_q <= '0;
      len_q    <= '0;
      cnt_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load) begin
        mode_q   <= mode;
        addr_q   <= base_addr;
        stride_q <= stride;
        len_q    <= length;
        cnt_q    <= '0;
      end else if (issue) begin
        addr_q <= addr_q + stride_q;
        cnt_q  <= cnt_q + LEN_WIDTH'(1);
      end
      // A pending done waits out any hold.
      if (done_set)   done_q <= 1'b1;
      else if (!hold) done_q <= 1'b0;
    end
  end

  // Tag pipeline, same depth and enable as the ROM data path.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      for (int i = 0; i < D; i++) idx_q[i] <= '0;
    end else if (!hold) begin
      vld_q[0] <= issue;
      idx_q[0] <= cnt_q;
      for (int i = 1; i < D; i++) begin
        vld_q[i] <= vld_q[i-1];
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  for (genvar l = 0; l < NUM_LANE; l++) begin : g_lane
    tf_rom_lane #(
      .COE_WIDTH   (COE_WIDTH),
      .ADDR_WIDTH  (ADDR_WIDTH),
      .LANE        (l),
      .Q_TYPE      (Q_TYPE),
      .DELAY       (D),
      .ROM_PATTERN (ROM_PATTERN)
    ) u_lane (
      .clk  (clk),
      .rst  (rst),
      .ce   (!hold),
      .addr ({mode_q, addr_q}),
      .dout (tf_data[l*COE_WIDTH +: COE_WIDTH])
    );
  end

  assign busy     = state_q != ST_IDLE;
  assign done     = done_q & ~hold;
  assign tf_valid = vld_q[D-1];
  assign tf_index = idx_q[D-1];

endmodule

// File: tb/tb_tf_rom_stream.sv
// Bench for tf_rom_stream using synthetic lane ROMs {mode, lane, addr}.
// Table bursts, hand sequences and random bursts against a word model.
module tb_tf_rom_stream;

  localparam int CW  = 39;
  localparam int AW  = 11;
  localparam int NL  = 4;
  localparam int DLY = 2;
  localparam int LW  = AW + 1;
  localparam int LIMIT = 400;

  logic clk = 1'b0;
  logic rst, start, mode, hold;
  logic [AW-1:0] base_addr, stride;
  logic [LW-1:0] length;
  logic busy, done, tf_valid;
  logic [NL*CW-1:0] tf_data;
  logic [LW-1:0] tf_index;

  always #5 clk = ~clk;

  tf_rom_stream #(
    .COE_WIDTH         (CW),
    .ADDR_WIDTH        (AW),
    .NUM_LANE          (NL),
    .Q_TYPE            (0),
    .COMMON_BRAM_DELAY (DLY),
    .LEN_WIDTH         (LW),
    .ROM_PATTERN       (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .mode      (mode),
    .base_addr (base_addr),
    .stride    (stride),
    .length    (length),
    .hold      (hold),
    .busy      (busy),
    .done      (done),
    .tf_valid  (tf_valid),
    .tf_data   (tf_data),
    .tf_index  (tf_index)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  typedef struct {
    int               idx;
    logic [NL*CW-1:0] data;
  } exp_t;

  exp_t exp_q[$];

  // Every lane returns {mode, lane[7:0], addr[10:0]} for its address.
  function automatic logic [NL*CW-1:0] model_word(input logic m,
                                                  input int a);
    logic [NL*CW-1:0] w;
    longint v;
    w = '0;
    for (int l = 0; l < NL; l++) begin
      v = longint'(m) * (longint'(1) << (AW + 8))
        + longint'(l) * (longint'(1) << AW)
        + longint'(a);
      w[l*CW +: CW] = CW'(v);
    end
    return w;
  endfunction

  task automatic push_burst(input logic m, input int b,
                            input int s, input int len);
    exp_t e;
    for (int k = 0; k < len; k++) begin
      e.idx  = k;
      e.data = model_word(m, (b + k * s) % (1 << AW));
      exp_q.push_back(e);
    end
  endtask

  // Output monitor: checks reset values, freeze under hold,
  // and each fresh word against the expected queue.
  logic [NL*CW-1:0] pd;
  logic             pv;
  logic [LW-1:0]    pi;
  int               last_addr = -1;
  exp_t             mon_e;
  logic             mh, mr;

  always @(posedge clk) begin
    mh = hold;
    mr = rst;
    #1;
    if (mr) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_valid", tf_valid, 0);
      check("rst_data", tf_data, 0);
      check("rst_index", tf_index, 0);
      exp_q.delete();
    end else if (mh) begin
      check("hold_data", tf_data, pd);
      check("hold_valid", tf_valid, pv);
      check("hold_index", tf_index, pi);
    end else if (tf_valid) begin
      if (exp_q.size() == 0) begin
        check("extra_word", tf_valid, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("word_index", tf_index, mon_e.idx);
        check("word_data", tf_data, mon_e.data);
      end
      last_addr = int'(tf_data[AW-1:0]);
    end
    pd = tf_data;
    pv = tf_valid;
    pi = tf_index;
  end

  // Runs one burst; k counts cycles from the start cycle (k=0).
  // lat is the k of the done cycle, first_v the k of first tf_valid.
  task automatic run_burst(input logic m, input int b, input int s,
                           input int len, input int hf, input int hl,
                           input int poke, input bit rnd,
                           output int lat, output int first_v,
                           output int busy_n);
    push_burst(m, b, s, len);
    lat = -1;
    first_v = -1;
    busy_n = 0;
    for (int k = 0; k < LIMIT; k++) begin
      start     = (k == 0) || (k == poke);
      mode      = (k == poke) ? ~m : m;
      base_addr = (k == poke) ? AW'(b + 100) : AW'(b);
      stride    = AW'(s);
      length    = (k == poke) ? LW'(3) : LW'(len);
      if (rnd) hold = ($urandom_range(0, 3) == 0);
      else     hold = (k >= hf) && (k < hf + hl);
      #1;
      if (k > 0) begin
        if (done && hold) check("done_in_hold", done, 0);
        if (tf_valid && first_v < 0) first_v = k;
        if (done) begin
          lat = k;
          check("busy_at_done", busy, 0);
          break;
        end
        if (busy) busy_n++;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    hold  = 1'b0;
  endtask

  typedef struct {
    logic m;
    int   base;
    int   stride;
    int   len;
    int   hf;
    int   hl;
    int   poke;
    int   exp_lat;
    int   exp_first;
    int   exp_last;
  } vec_t;

  vec_t vt[6];
  int lat, first_v, busy_n, n_done;

  initial begin
    vt[0] = '{1'b0,    0, 1, 8, 0, 0, -1, 11,  3,  7};
    vt[1] = '{1'b1, 2040, 3, 4, 0, 0, -1,  7,  3,  1};
    vt[2] = '{1'b0,    0, 1, 8, 4, 3, -1, 14,  3,  7};
    vt[3] = '{1'b0,    0, 1, 0, 0, 0, -1,  2, -1,  0};
    vt[4] = '{1'b0,   16, 2, 6, 0, 0,  3,  9,  3, 26};
    vt[5] = '{1'b1,    7, 5, 4, 0, 3, -1,  9,  5, 22};

    rst = 1'b1;
    start = 1'b0;
    hold = 1'b0;
    mode = 1'b0;
    base_addr = '0;
    stride = '0;
    length = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("idle_busy", busy, 0);

    foreach (vt[i]) begin
      run_burst(vt[i].m, vt[i].base, vt[i].stride, vt[i].len,
                vt[i].hf, vt[i].hl, vt[i].poke, 1'b0,
                lat, first_v, busy_n);
      check($sformatf("v%0d_done_lat", i), lat, vt[i].exp_lat);
      check($sformatf("v%0d_first_valid", i), first_v,
            vt[i].exp_first);
      check($sformatf("v%0d_busy_cycles", i), busy_n,
            vt[i].exp_lat - 1);
      if (vt[i].len > 0)
        check($sformatf("v%0d_last_addr", i), last_addr,
              vt[i].exp_last);
      @(posedge clk);
      #1;
      check($sformatf("v%0d_done_single", i), done, 0);
      check($sformatf("v%0d_words_left", i), exp_q.size(), 0);
    end

    // Reset in the cycle that issues index 4 of a 16-word burst.
    push_burst(1'b0, 5, 7, 16);
    mode = 1'b0;
    base_addr = AW'(5);
    stride = AW'(7);
    length = LW'(16);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 1; k < 5; k++) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    check("abort_busy", busy, 0);
    check("abort_valid", tf_valid, 0);
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk);
      #1;
      if (done) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_idle", busy, 0);

    // Random bursts with random hold patterns.
    for (int r = 0; r < 10; r++) begin
      run_burst(1'($urandom_range(0, 1)),
                int'($urandom_range(0, (1 << AW) - 1)),
                int'($urandom_range(0, (1 << AW) - 1)),
                int'($urandom_range(0, 20)),
                0, 0, -1, 1'b1, lat, first_v, busy_n);
      check($sformatf("r%0d_timeout", r), lat < 0, 0);
      @(posedge clk);
      #1;
      check($sformatf("r%0d_done_single", r), done, 0);
      check($sformatf("r%0d_words_left", r), exp_q.size(), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
